video_timing_gen: RTL

Parametrised raster timing generator. Produces sync, data-enable, pixel coordinates and frame/line markers for any progressive video mode. Adds clock-enable gating, synchronous resync, configurable sync polarity, registered outputs, a frame counter and a programmable line-match strobe. Sits at the head of the video output pipeline and drives the pixel fetch and encoder stages.

---
 rtl/video_timing_gen_pkg.sv | 40 ++++
 rtl/video_timing_gen_if.sv | 35 +++
 rtl/video_timing_gen_axis_counter.sv | 42 ++++
 rtl/video_timing_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg: shared raster timing types, mode presets and total-length helper.
// Contents:
//   axis_timing_t  - active/front-porch/sync/back-porch lengths of one raster axis
//   video_mode_t   - horizontal + vertical axis timing of a progressive mode
//   Mode*          - preset modes (640x480@60, 800x600@60, 1280x720@60)
//   axis_total()   - total axis length (active + porches + sync)
package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } video_mode_t;

    localparam video_mode_t Mode640x480p60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2, bp: 33}
    };

    localparam video_mode_t Mode800x600p60 = '{
        h: '{active: 800, fp: 40, sync: 128, bp: 88},
        v: '{active: 600, fp: 1, sync: 4, bp: 23}
    };

    localparam video_mode_t Mode1280x720p60 = '{
        h: '{active: 1280, fp: 110, sync: 40, bp: 220},
        v: '{active: 720, fp: 5, sync: 5, bp: 20}
    };

    function automatic int unsigned axis_total(axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: control inputs and raster outputs of the timing generator.
// Modports:
//   master - the generator: takes en/resync/line_sel, drives sync, vde, coordinates,
//            frame/line markers, line_match and frame_count
//   slave  - a downstream consumer / controller (mirror image of master)
interface video_timing_gen_if #(
    parameter int unsigned CW  = 12,
    parameter int unsigned FCW = 16
) ();
    logic           en;
    logic           resync;
    logic [CW-1:0]  line_sel;
    logic           hsync;
    logic           vsync;
    logic           vde;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           start_of_frame;
    logic           end_of_line;
    logic           end_of_frame;
    logic           line_match;
    logic [FCW-1:0] frame_count;

    modport master (
        input  en, resync, line_sel,
        output hsync, vsync, vde, x, y, start_of_frame, end_of_line, end_of_frame,
               line_match, frame_count
    );

    modport slave (
        output en, resync, line_sel,
        input  hsync, vsync, vde, x, y, start_of_frame, end_of_line, end_of_frame,
               line_match, frame_count
    );
endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// timing_axis_counter: wrapping position counter for one raster axis.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear_i      - synchronous load of 0, dominates inc_i
//   inc_i        - advance by one, wrapping from Total-1 to 0
//   count_o      - current position
//   wrap_o       - high while count_o == Total-1 (next increment wraps)
module timing_axis_counter #(
    parameter int unsigned Total = 800,
    parameter int unsigned Width = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);
    localparam logic [Width-1:0] Last = Width'(Total - 1);

    logic [Width-1:0] count_d, count_q;

    assign wrap_o  = (count_q == Last);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised progressive raster timing generator.
// Ports:
//   clk     - pixel clock
//   reset_n - asynchronous active-low reset
//   vid     - video_timing_gen_if.master: en/resync/line_sel in; hsync, vsync, vde, x, y,
//             start_of_frame, end_of_line, end_of_frame, line_match, frame_count out
// Every output is registered; position P appears one enabled edge after the counters hold P.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = Mode640x480p60.h.active,
    parameter int unsigned H_FP      = Mode640x480p60.h.fp,
    parameter int unsigned H_SYNC    = Mode640x480p60.h.sync,
    parameter int unsigned H_BP      = Mode640x480p60.h.bp,
    parameter int unsigned V_ACTIVE  = Mode640x480p60.v.active,
    parameter int unsigned V_FP      = Mode640x480p60.v.fp,
    parameter int unsigned V_SYNC    = Mode640x480p60.v.sync,
    parameter int unsigned V_BP      = Mode640x480p60.v.bp,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 12,
    parameter int unsigned FCW       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    video_timing_gen_if.master  vid
);
    localparam axis_timing_t HCfg = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_timing_t VCfg = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned  H_TOTAL  = axis_total(HCfg);
    localparam int unsigned  V_TOTAL  = axis_total(VCfg);
    localparam int unsigned  MaxTotal = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam bit CwOk    = (CW >= 32) || ((64'd1 << CW) > 64'(MaxTotal - 1));
    localparam bit ParamOk = (H_ACTIVE >= 1) && (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                             (V_ACTIVE >= 1) && (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1);

    if (!CwOk || !ParamOk) begin : g_param_check
        $error("video_timing_gen: bad timing parameters or CW too narrow");
    end

    localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HsStart  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HsEnd    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VsStart  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VsEnd    = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          vde;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          lm;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } out_t;

    localparam out_t OutReset = '{
        hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, vde: 1'b0, sof: 1'b0, eol: 1'b0, eof: 1'b0,
        lm: 1'b0, x: '0, y: '0
    };

    logic [CW-1:0]  h, v;
    logic           h_wrap, v_wrap;
    out_t           dec;
    out_t           out_d, out_q;
    logic [FCW-1:0] frame_count_d, frame_count_q;

    timing_axis_counter #(
        .Total (H_TOTAL),
        .Width (CW)
    ) u_h_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (vid.resync),
        .inc_i   (vid.en),
        .count_o (h),
        .wrap_o  (h_wrap)
    );

    timing_axis_counter #(
        .Total (V_TOTAL),
        .Width (CW)
    ) u_v_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (vid.resync),
        .inc_i   (vid.en & h_wrap),
        .count_o (v),
        .wrap_o  (v_wrap)
    );

    // Decode of the current counter position; captured into out_q on an enabled edge.
    always_comb begin
        dec       = OutReset;
        dec.x     = h;
        dec.y     = v;
        dec.vde   = (h < HActive) && (v < VActive);
        dec.hsync = ((h >= HsStart) && (h < HsEnd)) ? HSYNC_POL : ~HSYNC_POL;
        dec.vsync = ((v >= VsStart) && (v < VsEnd)) ? VSYNC_POL : ~VSYNC_POL;
        dec.sof   = (h == '0) && (v == '0);
        dec.eol   = h_wrap;
        dec.eof   = h_wrap && v_wrap;
        // v never reaches line_sel >= V_TOTAL, so such a setting silently never fires.
        dec.lm    = (h == HActive) && (v == vid.line_sel);
    end

    always_comb begin
        out_d         = out_q;
        frame_count_d = frame_count_q;
        if (vid.resync) begin
            out_d = OutReset;
        end else if (vid.en) begin
            out_d = dec;
            if (h_wrap && v_wrap) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q         <= OutReset;
            frame_count_q <= '0;
        end else begin
            out_q         <= out_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vid.hsync          = out_q.hsync;
    assign vid.vsync          = out_q.vsync;
    assign vid.vde            = out_q.vde;
    assign vid.x              = out_q.x;
    assign vid.y              = out_q.y;
    assign vid.start_of_frame = out_q.sof;
    assign vid.end_of_line    = out_q.eol;
    assign vid.end_of_frame   = out_q.eof;
    assign vid.line_match     = out_q.lm;
    assign vid.frame_count    = frame_count_q;
endmodule
